iob2apb: RTL and testbench

IOB2APB -- requirements
Module: iob2apb

---
 rtl/iob2apb.sv | 158 +++++++++++++++
 tb/tb_iob2apb.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob2apb.sv
// Purpose: bridge IOb native requests onto an APB requester, one transfer in flight.
// Latency: accept at T, SETUP T+1, ACCESS T+2 until PREADY or timeout, response and ready one cycle after completion.
// Backpressure: iob_ready_o is low while a transfer is outstanding; PREADY low stalls ACCESS for up to TIMEOUT cycles.
module iob2apb #(
    parameter int APB_ADDR_W = 32,
    parameter int APB_DATA_W = 32,
    parameter int ADDR_W     = APB_ADDR_W,
    parameter int DATA_W     = APB_DATA_W,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_n_i,
    input  logic                    iob_avalid_i,
    input  logic [ADDR_W-1:0]       iob_addr_i,
    input  logic [DATA_W-1:0]       iob_wdata_i,
    input  logic [DATA_W/8-1:0]     iob_wstrb_i,
    output logic                    iob_ready_o,
    output logic                    iob_rvalid_o,
    output logic [DATA_W-1:0]       iob_rdata_o,
    output logic                    err_o,
    output logic                    apb_sel_o,
    output logic                    apb_enable_o,
    output logic                    apb_write_o,
    output logic [APB_ADDR_W-1:0]   apb_addr_o,
    output logic [APB_DATA_W-1:0]   apb_wdata_o,
    output logic [APB_DATA_W/8-1:0] apb_wstrb_o,
    input  logic                    apb_ready_i,
    input  logic [APB_DATA_W-1:0]   apb_rdata_i,
    input  logic                    apb_slverr_i
);

    localparam int STRB_W = APB_DATA_W / 8;
    localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [STRB_W-1:0]     wstrb;
    } req_t;

    state_t              state_q, state_d;
    req_t                req_q, req_d;
    logic                sel_q, sel_d;
    logic                en_q, en_d;
    logic                rdy_q, rdy_d;
    logic                rvld_q, rvld_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                timeout_hit;

    // Counter holds the number of stalled ACCESS cycles already spent, so the
    // current cycle is the TIMEOUT-th one when cnt+1 reaches TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt_q} + 17'd1) == TIMEOUT_CNT);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        en_d    = en_q;
        rdy_d   = rdy_q;
        rvld_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (rdy_q && iob_avalid_i) begin
                    req_d.write = |iob_wstrb_i;
                    req_d.addr  = iob_addr_i;
                    req_d.wdata = iob_wdata_i;
                    req_d.wstrb = iob_wstrb_i;
                    state_d     = SETUP;
                    sel_d       = 1'b1;
                    en_d        = 1'b0;
                    rdy_d       = 1'b0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                sel_d   = 1'b1;
                en_d    = 1'b1;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (apb_ready_i) begin
                    state_d = IDLE;
                    sel_d   = 1'b0;
                    en_d    = 1'b0;
                    rdy_d   = 1'b1;
                    err_d   = apb_slverr_i;
                    if (!req_q.write) begin
                        rvld_d  = 1'b1;
                        rdata_d = apb_rdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    sel_d   = 1'b0;
                    en_d    = 1'b0;
                    rdy_d   = 1'b1;
                    err_d   = 1'b1;
                    if (!req_q.write) begin
                        rvld_d  = 1'b1;
                        rdata_d = '1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 1'b0;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
            rvld_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
            rvld_q  <= rvld_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign iob_ready_o  = rdy_q;
    assign iob_rvalid_o = rvld_q;
    assign iob_rdata_o  = rdata_q;
    assign err_o        = err_q;
    assign apb_sel_o    = sel_q;
    assign apb_enable_o = en_q;
    assign apb_write_o  = req_q.write;
    assign apb_addr_o   = req_q.addr;
    assign apb_wdata_o  = req_q.wdata;
    assign apb_wstrb_o  = req_q.wstrb;

endmodule

// File: tb/tb_iob2apb.sv
// Purpose: self-checking bench for iob2apb against a transaction-level model.
// Latency: every transfer is checked for SETUP/ACCESS cycle counts and response cycle.
// Backpressure: slave wait states and clock-enable stalls are driven from the bench.
module tb_iob2apb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          cke_i = 1'b1;
    logic          arst_n_i = 1'b0;
    logic          iob_avalid_i = 1'b0;
    logic [AW-1:0] iob_addr_i = '0;
    logic [DW-1:0] iob_wdata_i = '0;
    logic [SW-1:0] iob_wstrb_i = '0;
    logic          iob_ready_o;
    logic          iob_rvalid_o;
    logic [DW-1:0] iob_rdata_o;
    logic          err_o;
    logic          apb_sel_o;
    logic          apb_enable_o;
    logic          apb_write_o;
    logic [AW-1:0] apb_addr_o;
    logic [DW-1:0] apb_wdata_o;
    logic [SW-1:0] apb_wstrb_o;
    logic          apb_ready_i = 1'b0;
    logic [DW-1:0] apb_rdata_i = '0;
    logic          apb_slverr_i = 1'b0;

    always #5 clk_i = ~clk_i;

    iob2apb #(
        .APB_ADDR_W(AW), .APB_DATA_W(DW), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i),
        .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i),
        .iob_wstrb_i(iob_wstrb_i), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
        .iob_rdata_o(iob_rdata_o), .err_o(err_o),
        .apb_sel_o(apb_sel_o), .apb_enable_o(apb_enable_o), .apb_write_o(apb_write_o),
        .apb_addr_o(apb_addr_o), .apb_wdata_o(apb_wdata_o), .apb_wstrb_o(apb_wstrb_o),
        .apb_ready_i(apb_ready_i), .apb_rdata_i(apb_rdata_i), .apb_slverr_i(apb_slverr_i)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct {
        bit            accepted;
        bit            setup1;
        int            n_access;
        int            done_cyc;
        int            n_rvalid;
        int            n_err;
        int            rv_cyc;
        int            err_cyc;
        logic [DW-1:0] rdata;
        int            bad;
        logic          sel_done;
    } obs_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model_rdata = '0;

    // Transaction-level expectation: a transfer spends min(waits+1, TIMEOUT)
    // cycles in ACCESS; the response appears two cycles after that count.
    task automatic predict(input req_t r, input int waits, input logic [DW-1:0] srd,
                           input logic serr, output obs_t e);
        bit is_wr;
        bit to;
        is_wr = (r.wstrb != 0);
        to = (TO != 0) && (waits >= TO);
        e.accepted = 1'b1;
        e.setup1   = 1'b1;
        e.n_access = to ? TO : waits + 1;
        e.done_cyc = e.n_access + 2;
        e.n_rvalid = is_wr ? 0 : 1;
        e.n_err    = (to || serr) ? 1 : 0;
        e.rv_cyc   = is_wr ? -1 : e.done_cyc;
        e.err_cyc  = (e.n_err != 0) ? e.done_cyc : -1;
        if (!is_wr) model_rdata = to ? '1 : srd;
        e.rdata    = model_rdata;
        e.bad      = 0;
        e.sel_done = 1'b0;
    endtask

    // Runs one transfer with an APB slave that answers after 'waits' stalled
    // ACCESS cycles; outside ACCESS the slave drives random junk.
    task automatic xfer(input req_t r, input int waits, input logic [DW-1:0] srd,
                        input logic serr, input bit chained, input bit hold,
                        input req_t nxt, output obs_t o);
        int acc;
        acc = 0;
        o.accepted = 1'b0; o.setup1 = 1'b0; o.n_access = 0; o.done_cyc = -1;
        o.n_rvalid = 0; o.n_err = 0; o.rv_cyc = -1; o.err_cyc = -1;
        o.rdata = '0; o.bad = 0; o.sel_done = 1'b1;
        if (!chained) begin
            @(posedge clk_i); #1;
            iob_avalid_i = 1'b1;
            iob_addr_i = r.addr; iob_wdata_i = r.wdata; iob_wstrb_i = r.wstrb;
            @(negedge clk_i);
        end
        o.accepted = iob_ready_o;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk_i); #1;
            if (hold) begin
                iob_avalid_i = 1'b1;
                iob_addr_i = nxt.addr; iob_wdata_i = nxt.wdata; iob_wstrb_i = nxt.wstrb;
            end else begin
                iob_avalid_i = 1'b0;
                iob_addr_i = $urandom; iob_wdata_i = $urandom; iob_wstrb_i = SW'($urandom);
            end
            apb_ready_i = 1'($urandom); apb_rdata_i = $urandom; apb_slverr_i = 1'($urandom);
            if (apb_sel_o && apb_enable_o) begin
                apb_ready_i = (acc == waits);
                if (acc == waits) begin
                    apb_rdata_i = srd; apb_slverr_i = serr;
                end
                acc++;
            end
            @(negedge clk_i);
            if (cyc == 1) o.setup1 = apb_sel_o && !apb_enable_o;
            if (apb_sel_o && apb_enable_o) o.n_access++;
            if (iob_rvalid_o) begin o.n_rvalid++; o.rv_cyc = cyc; end
            if (err_o) begin o.n_err++; o.err_cyc = cyc; end
            if (apb_addr_o !== r.addr || apb_wdata_o !== r.wdata || apb_wstrb_o !== r.wstrb ||
                apb_write_o !== (r.wstrb != 0)) o.bad++;
            if (iob_ready_o) begin
                o.done_cyc = cyc; o.rdata = iob_rdata_o; o.sel_done = apb_sel_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        checks++;
        if ({iob_ready_o, iob_rvalid_o, err_o, apb_sel_o, apb_enable_o, apb_write_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {iob_ready_o, iob_rvalid_o, err_o, apb_sel_o, apb_enable_o, apb_write_o});
        end
        checks++;
        if (iob_rdata_o !== '0 || apb_addr_o !== '0 || apb_wdata_o !== '0 || apb_wstrb_o !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h wstrb %h expected all zero",
                     iob_rdata_o, apb_addr_o, apb_wdata_o, apb_wstrb_o);
        end
        #3 arst_n_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (iob_ready_o !== 1'b1 || apb_sel_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready %b sel %b expected ready 1 sel 0", iob_ready_o, apb_sel_o);
        end
    endtask

    task automatic test_read();
        req_t r; obs_t o, e;
        r.addr = 32'h10; r.wdata = $urandom; r.wstrb = '0;
        predict(r, 0, 32'hDEADBEEF, 1'b0, e);
        xfer(r, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, r, o);
        checks++;
        if (!o.accepted || !o.setup1 || o.n_access !== 1) begin
            errors++;
            $display("FAIL read_phases: acc %0d setup %0d access %0d expected 1 1 1", o.accepted, o.setup1, o.n_access);
        end
        checks++;
        if (o.rv_cyc !== 3 || o.done_cyc !== 3) begin
            errors++;
            $display("FAIL read_latency: rvalid cyc %0d ready cyc %0d expected 3 3", o.rv_cyc, o.done_cyc);
        end
        checks++;
        if (o.rdata !== 32'hDEADBEEF || o.n_err !== 0 || o.bad !== 0) begin
            errors++;
            $display("FAIL read_data: rdata %h err %0d badfields %0d expected deadbeef 0 0", o.rdata, o.n_err, o.bad);
        end
        @(negedge clk_i);
        checks++;
        if (iob_rvalid_o !== 1'b0 || err_o !== 1'b0 || iob_rdata_o !== e.rdata) begin
            errors++;
            $display("FAIL read_pulse_width: rvalid %b err %b rdata %h expected 0 0 %h",
                     iob_rvalid_o, err_o, iob_rdata_o, e.rdata);
        end
    endtask

    task automatic test_write();
        req_t r; obs_t o, e;
        r.addr = 32'h20; r.wdata = 32'h12345678; r.wstrb = 4'hF;
        predict(r, 3, $urandom, 1'b0, e);
        xfer(r, 3, $urandom, 1'b0, 1'b0, 1'b0, r, o);
        checks++;
        if (o.n_access !== 4 || o.bad !== 0) begin
            errors++;
            $display("FAIL write_access: access %0d badfields %0d expected 4 0", o.n_access, o.bad);
        end
        checks++;
        if (o.n_rvalid !== 0 || o.n_err !== 0 || o.done_cyc !== 6) begin
            errors++;
            $display("FAIL write_resp: rvalid %0d err %0d ready cyc %0d expected 0 0 6", o.n_rvalid, o.n_err, o.done_cyc);
        end
        checks++;
        if (o.rdata !== e.rdata) begin
            errors++;
            $display("FAIL write_rdata_hold: got %h expected %h", o.rdata, e.rdata);
        end
    endtask

    task automatic test_slverr();
        req_t r; obs_t o, e; int w; logic [DW-1:0] d;
        r.addr = $urandom; r.wdata = $urandom; r.wstrb = '0;
        w = $urandom_range(0, 3); d = $urandom;
        predict(r, w, d, 1'b1, e);
        xfer(r, w, d, 1'b1, 1'b0, 1'b0, r, o);
        checks++;
        if (o.n_rvalid !== 1 || o.n_err !== 1 || o.rv_cyc !== o.err_cyc || o.rv_cyc !== e.done_cyc) begin
            errors++;
            $display("FAIL slverr_pulses: rvalid %0d@%0d err %0d@%0d expected 1@%0d 1@%0d",
                     o.n_rvalid, o.rv_cyc, o.n_err, o.err_cyc, e.done_cyc, e.done_cyc);
        end
        checks++;
        if (o.rdata !== d) begin
            errors++;
            $display("FAIL slverr_rdata: got %h expected %h", o.rdata, d);
        end
        @(negedge clk_i);
        checks++;
        if (iob_rvalid_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL slverr_pulse_width: rvalid %b err %b expected 0 0", iob_rvalid_o, err_o);
        end
    endtask

    task automatic test_timeout();
        req_t r; obs_t o, e;
        r.addr = 32'h30; r.wdata = $urandom; r.wstrb = '0;
        predict(r, 1000, 32'h0, 1'b0, e);
        xfer(r, 1000, 32'h0, 1'b0, 1'b0, 1'b0, r, o);
        checks++;
        if (o.n_access !== 4 || o.done_cyc !== 6 || o.sel_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cycles: access %0d ready cyc %0d sel %b expected 4 6 0", o.n_access, o.done_cyc, o.sel_done);
        end
        checks++;
        if (o.rdata !== 32'hFFFFFFFF || o.n_rvalid !== 1 || o.n_err !== 1) begin
            errors++;
            $display("FAIL timeout_resp: rdata %h rvalid %0d err %0d expected ffffffff 1 1", o.rdata, o.n_rvalid, o.n_err);
        end
    endtask

    task automatic test_back_to_back();
        req_t r1, r2; obs_t o1, o2, e1, e2; logic [DW-1:0] d1, d2;
        r1.addr = 32'h100; r1.wdata = $urandom; r1.wstrb = '0;
        r2.addr = 32'h104; r2.wdata = $urandom; r2.wstrb = '0;
        d1 = $urandom; d2 = $urandom;
        predict(r1, 0, d1, 1'b0, e1);
        xfer(r1, 0, d1, 1'b0, 1'b0, 1'b1, r2, o1);
        predict(r2, 0, d2, 1'b0, e2);
        xfer(r2, 0, d2, 1'b0, 1'b1, 1'b0, r2, o2);
        checks++;
        if (o1.rv_cyc !== 3 || o1.rdata !== e1.rdata) begin
            errors++;
            $display("FAIL b2b_first: rvalid cyc %0d rdata %h expected 3 %h", o1.rv_cyc, o1.rdata, e1.rdata);
        end
        checks++;
        if (o1.sel_done !== 1'b0 || !o2.accepted || !o2.setup1) begin
            errors++;
            $display("FAIL b2b_gap: sel in gap %b accepted %0d setup next %0d expected 0 1 1", o1.sel_done, o2.accepted, o2.setup1);
        end
        checks++;
        if (o2.done_cyc !== 3 || o2.rdata !== e2.rdata || o2.bad !== 0) begin
            errors++;
            $display("FAIL b2b_second: ready cyc %0d rdata %h badfields %0d expected 3 %h 0", o2.done_cyc, o2.rdata, o2.bad, e2.rdata);
        end
    endtask

    task automatic test_cke();
        logic [DW-1:0] d;
        d = $urandom;
        @(posedge clk_i); #1;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h40; iob_wstrb_i = '0; apb_ready_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        iob_avalid_i = 1'b0; cke_i = 1'b0; apb_ready_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if (apb_sel_o !== 1'b1 || apb_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL cke_hold_setup: sel %b en %b expected 1 0", apb_sel_o, apb_enable_o);
        end
        @(posedge clk_i); #1;
        cke_i = 1'b1;
        @(posedge clk_i); #1;
        cke_i = 1'b0; apb_ready_i = 1'b1; apb_rdata_i = ~d;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if (apb_enable_o !== 1'b1 || iob_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL cke_hold_access: en %b rvalid %b expected 1 0", apb_enable_o, iob_rvalid_o);
        end
        cke_i = 1'b1; apb_ready_i = 1'b1; apb_rdata_i = d; apb_slverr_i = 1'b0;
        @(posedge clk_i); #1;
        cke_i = 1'b0; apb_rdata_i = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (iob_rvalid_o !== 1'b1 || iob_rdata_o !== d || iob_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL cke_pulse_stretch[%0d]: rvalid %b rdata %h ready %b expected 1 %h 1",
                         i, iob_rvalid_o, iob_rdata_o, iob_ready_o, d);
            end
            @(posedge clk_i); #1;
        end
        cke_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if (iob_rvalid_o !== 1'b0 || iob_rdata_o !== d) begin
            errors++;
            $display("FAIL cke_pulse_end: rvalid %b rdata %h expected 0 %h", iob_rvalid_o, iob_rdata_o, d);
        end
        model_rdata = d;
    endtask

    task automatic test_reset_mid();
        req_t r; obs_t o, e; logic [DW-1:0] d;
        @(posedge clk_i); #1;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h80; iob_wstrb_i = '0; apb_ready_i = 1'b0;
        @(posedge clk_i); #1;
        iob_avalid_i = 1'b0;
        @(posedge clk_i); #1;
        apb_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (apb_enable_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_enter_access: en %b expected 1", apb_enable_o);
        end
        #2 arst_n_i = 1'b0;
        #1;
        checks++;
        if ({apb_sel_o, apb_enable_o, iob_rvalid_o, err_o, iob_ready_o} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_immediate: sel/en/rvalid/err/ready %b expected 00000",
                     {apb_sel_o, apb_enable_o, iob_rvalid_o, err_o, iob_ready_o});
        end
        apb_ready_i = 1'b1; apb_slverr_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #3 arst_n_i = 1'b1;
        model_rdata = '0;
        @(negedge clk_i);
        checks++;
        if (iob_rvalid_o !== 1'b0 || err_o !== 1'b0 || iob_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_release: rvalid %b err %b ready %b expected 0 0 1", iob_rvalid_o, err_o, iob_ready_o);
        end
        r.addr = 32'h84; r.wdata = $urandom; r.wstrb = '0; d = $urandom;
        predict(r, 1, d, 1'b0, e);
        xfer(r, 1, d, 1'b0, 1'b0, 1'b0, r, o);
        checks++;
        if (o.rdata !== d || o.n_rvalid !== 1 || o.n_err !== 0 || o.done_cyc !== e.done_cyc) begin
            errors++;
            $display("FAIL rst_mid_next_read: rdata %h rvalid %0d err %0d cyc %0d expected %h 1 0 %0d",
                     o.rdata, o.n_rvalid, o.n_err, o.done_cyc, d, e.done_cyc);
        end
    endtask

    task automatic test_random();
        req_t r; obs_t o, e; int w; logic [DW-1:0] d; logic s;
        for (int i = 0; i < 40; i++) begin
            r.addr = $urandom; r.wdata = $urandom;
            r.wstrb = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 15)) : '0;
            w = $urandom_range(0, 6); d = $urandom; s = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            predict(r, w, d, s, e);
            xfer(r, w, d, s, 1'b0, 1'b0, r, o);
            checks++;
            if (o.accepted !== e.accepted || o.setup1 !== e.setup1 || o.n_access !== e.n_access ||
                o.done_cyc !== e.done_cyc || o.sel_done !== e.sel_done || o.bad !== e.bad) begin
                errors++;
                $display("FAIL rand[%0d]_timing: acc %0d setup %0d access %0d cyc %0d sel %b bad %0d expected %0d %0d %0d %0d %b %0d",
                         i, o.accepted, o.setup1, o.n_access, o.done_cyc, o.sel_done, o.bad,
                         e.accepted, e.setup1, e.n_access, e.done_cyc, e.sel_done, e.bad);
            end
            checks++;
            if (o.n_rvalid !== e.n_rvalid || o.rv_cyc !== e.rv_cyc || o.n_err !== e.n_err ||
                o.err_cyc !== e.err_cyc || o.rdata !== e.rdata) begin
                errors++;
                $display("FAIL rand[%0d]_resp: rvalid %0d@%0d err %0d@%0d rdata %h expected %0d@%0d %0d@%0d %h",
                         i, o.n_rvalid, o.rv_cyc, o.n_err, o.err_cyc, o.rdata,
                         e.n_rvalid, e.rv_cyc, e.n_err, e.err_cyc, e.rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_cke();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
